// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers; MTHI/MTLO write in one cycle.
// Latency: MUL/DIV results land WIDTH+1 edges after the start edge; MTHI/MTLO land at the start edge.
// Backpressure: busy is high while an op is in flight, and start is ignored then. Optional MDU_EARLY_OUT_EN skips ITER when b==0.
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FINAL} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;     // product high half / partial remainder
    logic [WIDTH-1:0] mq_q, mq_d;       // multiplier / dividend shifting into quotient
    logic [WIDTH-1:0] opd_q, opd_d;     // multiplicand magnitude / divisor magnitude
    logic [WIDTH-1:0] araw_q, araw_d;   // original dividend, returned as hi on divide by zero
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;     // product or quotient must be negated
    logic             rneg_q, rneg_d;   // remainder must be negated (dividend sign)
    logic             bzero_q, bzero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic               is_signed;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     sum, shl, diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;

    // Next-state, datapath step and result correction for the whole unit.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mq_d     = mq_q;
        opd_d    = opd_q;
        araw_d   = araw_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        bzero_d  = bzero_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        is_signed = (op == 3'b000) || (op == 3'b010);
        a_abs     = (is_signed && a[WIDTH-1]) ? -a : a;
        b_abs     = (is_signed && b[WIDTH-1]) ? -b : b;

        // One shift-add multiply step: add multiplicand if multiplier lsb set, then shift right.
        sum  = {1'b0, acc_q} + {1'b0, opd_q};
        // One restoring divide step: shift next dividend bit in, trial-subtract divisor.
        shl  = {acc_q, mq_q[WIDTH-1]};
        diff = shl - {1'b0, opd_q};

        prod = neg_q  ? -{acc_q, mq_q} : {acc_q, mq_q};
        quo  = neg_q  ? -mq_q  : mq_q;
        rem  = rneg_q ? -acc_q : acc_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        3'b000, 3'b001, 3'b010, 3'b011: begin
                            is_div_d = op[1];
                            neg_d    = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                            rneg_d   = is_signed & a[WIDTH-1];
                            bzero_d  = (b == '0);
                            araw_d   = a;
                            acc_d    = '0;
                            cnt_d    = '0;
                            if (op[1]) begin
                                mq_d  = a_abs;
                                opd_d = b_abs;
                            end else begin
                                mq_d  = b_abs;
                                opd_d = a_abs;
                            end
`ifdef MDU_EARLY_OUT_EN
                            state_d = (b == '0) ? S_FINAL : S_ITER;
`else
                            state_d = S_ITER;
`endif
                        end
                        3'b100:  hi_d = a;
                        3'b101:  lo_d = a;
                        default: ;
                    endcase
                end
            end
            S_ITER: begin
                if (is_div_q) begin
                    acc_d = diff[WIDTH] ? shl[WIDTH-1:0] : diff[WIDTH-1:0];
                    mq_d  = {mq_q[WIDTH-2:0], ~diff[WIDTH]};
                end else if (mq_q[0]) begin
                    acc_d = sum[WIDTH:1];
                    mq_d  = {sum[0], mq_q[WIDTH-1:1]};
                end else begin
                    acc_d = {1'b0, acc_q[WIDTH-1:1]};
                    mq_d  = {acc_q[0], mq_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_FINAL;
                end
            end
            S_FINAL: begin
                if (bzero_q) begin
                    hi_d = is_div_q ? araw_q : '0;
                    lo_d = is_div_q ? '1     : '0;
                end else if (is_div_q) begin
                    hi_d = rem;
                    lo_d = quo;
                end else begin
                    {hi_d, lo_d} = prod;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset that aborts any op in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mq_q     <= '0;
            opd_q    <= '0;
            araw_q   <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            bzero_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mq_q     <= mq_d;
            opd_q    <= opd_d;
            araw_q   <= araw_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            bzero_q  <= bzero_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit: MUL/DIV results, latency, MTHI/MTLO, ignored starts, reset abort.
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: starts issued while busy are expected to be dropped.
module tb_mul_div_unit;

    localparam int WIDTH = 32;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [2:0]       op    = 3'b111;
    logic [WIDTH-1:0] a     = '0;
    logic [WIDTH-1:0] b     = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int n_chk  = 0;
    int n_pass = 0;

    mul_div_unit #(.WIDTH(WIDTH), .CNT_W(5)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int exp_lat(input logic [WIDTH-1:0] bv);
`ifdef MDU_EARLY_OUT_EN
        return (bv == '0) ? 1 : WIDTH + 1;
`else
        return WIDTH + 1;
`endif
    endfunction

    // Issue one MUL/DIV, wait (bounded) for done, check latency, busy span, result and pulse width.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [WIDTH-1:0] av,
                          input logic [WIDTH-1:0] bv, input logic [WIDTH-1:0] ehi,
                          input logic [WIDTH-1:0] elo);
        int lat;
        int busy_cnt;
        @(negedge clock);
        start = 1'b1; op = o; a = av; b = bv;
        @(negedge clock);
        start = 1'b0; op = 3'b111;
        busy_cnt = busy ? 1 : 0;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (done) begin
                lat = i;
                break;
            end
            if (busy) busy_cnt++;
        end
        check({tag, "_lat"},  64'(lat),      64'(exp_lat(bv)));
        check({tag, "_busy"}, 64'(busy_cnt), 64'(exp_lat(bv)));
        check({tag, "_hi"},   64'(hi),       64'(ehi));
        check({tag, "_lo"},   64'(lo),       64'(elo));
        @(negedge clock);
        check({tag, "_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int done_cnt;

        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi",   64'(hi),   64'd0);
        check("rst_lo",   64'(lo),   64'd0);

        run_op("mult",   3'b000, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA);
        run_op("multu",  3'b001, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA);
        run_op("mult_nn",3'b000, 32'hFFFFFFFB, 32'hFFFFFFFC, 32'h00000000, 32'h00000014);
        run_op("div",    3'b010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_pn", 3'b010, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        run_op("divu",   3'b011, 32'd100,      32'd7,        32'h00000002, 32'h0000000E);
        run_op("divu_z", 3'b011, 32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF);
        run_op("div_ov", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        run_op("div_z",  3'b010, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF);

        // Undefined op: nothing changes.
        @(negedge clock);
        start = 1'b1; op = 3'b110; a = 32'h11111111; b = 32'h22222222;
        @(negedge clock);
        start = 1'b0; op = 3'b111;
        check("undef_busy", 64'(busy), 64'd0);
        check("undef_hi",   64'(hi),   64'hFFFFFFF9);
        check("undef_lo",   64'(lo),   64'hFFFFFFFF);

        // MTHI then MTLO on consecutive edges.
        @(negedge clock);
        start = 1'b1; op = 3'b100; a = 32'hCAFEBABE;
        @(negedge clock);
        check("mthi_hi",   64'(hi),   64'hCAFEBABE);
        check("mthi_busy", 64'(busy), 64'd0);
        op = 3'b101; a = 32'h0BADF00D;
        @(negedge clock);
        start = 1'b0; op = 3'b111;
        check("mtlo_lo",   64'(lo),   64'h0BADF00D);
        check("mtlo_hi",   64'(hi),   64'hCAFEBABE);
        check("mtlo_busy", 64'(busy), 64'd0);
        check("mtlo_done", 64'(done), 64'd0);

        // Starts during a MULT are dropped.
        @(negedge clock);
        start = 1'b1; op = 3'b001; a = 32'd7; b = 32'd6;
        @(negedge clock);
        start = 1'b0; op = 3'b111;
        done_cnt = 0;
        for (int i = 1; i <= 45; i++) begin
            if (i == 3) begin
                start = 1'b1; op = 3'b101; a = 32'd5;
            end else if (i == 5) begin
                start = 1'b1; op = 3'b011; a = 32'd100; b = 32'd7;
            end else begin
                start = 1'b0; op = 3'b111;
            end
            @(negedge clock);
            if (done) done_cnt++;
            if (i == 3) check("ign_mtlo", 64'(lo), 64'h0BADF00D);
        end
        check("ign_done_cnt", 64'(done_cnt), 64'd1);
        check("ign_hi",       64'(hi),       64'd0);
        check("ign_lo",       64'(lo),       64'd42);
        check("ign_busy",     64'(busy),     64'd0);

        // Reset with the iteration counter at 10.
        @(negedge clock);
        start = 1'b1; op = 3'b000; a = 32'h00001234; b = 32'h00005678;
        @(negedge clock);
        start = 1'b0; op = 3'b111;
        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hi",   64'(hi),   64'd0);
        check("abort_lo",   64'(lo),   64'd0);
        done_cnt = 0;
        for (int i = 0; i < 35; i++) begin
            @(negedge clock);
            if (done || busy) done_cnt++;
        end
        check("abort_quiet", 64'(done_cnt), 64'd0);
        run_op("post_rst", 3'b001, 32'd6, 32'd7, 32'd0, 32'd42);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
